// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite compositor: colour, coordinate and
// ROM-address widths, plus the default colour key and background.
package sprite_pkg;

    localparam int COORD_W = 16;
    localparam int ADDR_W  = 8;

    typedef logic [23:0]        colour_t;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    localparam colour_t DEF_KEY_COLOUR = 24'hFF0096;
    localparam colour_t DEF_BG_COLOUR  = 24'h70C5CE;

    // Per-pixel control that rides the delay line next to the sprite hits.
    typedef struct packed {
        logic frame_start;
        logic display_on;
    } pix_ctl_t;

endpackage

// File: rtl/sprite_hit_addr.sv
// Per-sprite stage-A logic: bounds check against the scaled sprite box and
// ROM row/column generation, with optional column mirroring.
module sprite_hit_addr
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 17,
    parameter int SPR_H      = 12,
    parameter int SCALE_LOG2 = 1
) (
    input  coord_t x,
    input  coord_t y,
    input  coord_t spr_x,
    input  coord_t spr_y,
    input  logic   en,
    input  logic   flip,
    output logic   hit,
    output addr_t  row,
    output addr_t  col
);

    localparam coord_t W_PIX    = coord_t'(SPR_W << SCALE_LOG2);
    localparam coord_t H_PIX    = coord_t'(SPR_H << SCALE_LOG2);
    localparam addr_t  LAST_COL = addr_t'(SPR_W - 1);

    coord_t dx;
    coord_t dy;
    addr_t  col_raw;

    // Modular subtraction makes pixels left of / above the sprite wrap large,
    // so a single unsigned compare covers off-screen and partial sprites.
    always_comb begin
        dx      = x - spr_x;
        dy      = y - spr_y;
        hit     = en && (dx < W_PIX) && (dy < H_PIX);
        row     = addr_t'(dy >> SCALE_LOG2);
        col_raw = addr_t'(dx >> SCALE_LOG2);
        col     = flip ? (LAST_COL - col_raw) : col_raw;
    end

endmodule

// File: rtl/sprite_compositor.sv
// Pipelined multi-sprite compositor with colour-key transparency and a per-frame
// player collision latch. Build option SPRITE_COMPOSITOR_MIRROR_EN adds spr_flip.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int      NUM_SPRITES = 4,
    parameter int      SPR_W       = 17,
    parameter int      SPR_H       = 12,
    parameter int      SCALE_LOG2  = 1,
    parameter int      ROM_LATENCY = 1,
    parameter colour_t KEY_COLOUR  = DEF_KEY_COLOUR,
    parameter colour_t BG_COLOUR   = DEF_BG_COLOUR
) (
    input  logic                                  VGA_clk,
    input  logic                                  rst,
    input  logic                                  display_on,
    input  logic                                  frame_start,
    input  logic [COORD_W-1:0]                    X,
    input  logic [COORD_W-1:0]                    Y,
    input  logic [NUM_SPRITES-1:0][COORD_W-1:0]   spr_x,
    input  logic [NUM_SPRITES-1:0][COORD_W-1:0]   spr_y,
    input  logic [NUM_SPRITES-1:0]                spr_en,
`ifdef SPRITE_COMPOSITOR_MIRROR_EN
    input  logic [NUM_SPRITES-1:0]                spr_flip,
`endif
    output logic [NUM_SPRITES-1:0][ADDR_W-1:0]    rom_row,
    output logic [NUM_SPRITES-1:0][ADDR_W-1:0]    rom_col,
    input  logic [NUM_SPRITES-1:0][23:0]          rom_data,
    output logic [23:0]                           RGB,
    output logic                                  collision,
    output logic [NUM_SPRITES-1:0]                collision_mask
);

    logic [NUM_SPRITES-1:0]              flip_w;
    logic [NUM_SPRITES-1:0]              hit_a;
    logic [NUM_SPRITES-1:0][ADDR_W-1:0]  row_a;
    logic [NUM_SPRITES-1:0][ADDR_W-1:0]  col_a;

`ifdef SPRITE_COMPOSITOR_MIRROR_EN
    assign flip_w = spr_flip;
`else
    assign flip_w = '0;
`endif

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
        sprite_hit_addr #(
            .SPR_W      (SPR_W),
            .SPR_H      (SPR_H),
            .SCALE_LOG2 (SCALE_LOG2)
        ) u_hit_addr (
            .x     (X),
            .y     (Y),
            .spr_x (spr_x[i]),
            .spr_y (spr_y[i]),
            .en    (spr_en[i]),
            .flip  (flip_w[i]),
            .hit   (hit_a[i]),
            .row   (row_a[i]),
            .col   (col_a[i])
        );
    end

    // Index 0 is the stage-A register; index ROM_LATENCY lines up with rom_data.
    logic [ROM_LATENCY:0][NUM_SPRITES-1:0]  hit_pipe_q, hit_pipe_d;
    pix_ctl_t [ROM_LATENCY:0]               ctl_pipe_q, ctl_pipe_d;
    logic [NUM_SPRITES-1:0][ADDR_W-1:0]     rom_row_q, rom_row_d;
    logic [NUM_SPRITES-1:0][ADDR_W-1:0]     rom_col_q, rom_col_d;
    colour_t                                rgb_q, rgb_d;
    logic [NUM_SPRITES-1:0]                 mask_q, mask_d;
    logic                                   coll_q, coll_d;

    logic [NUM_SPRITES-1:0]                 hit_c;
    pix_ctl_t                               ctl_c;
    logic [NUM_SPRITES-1:0]                 opaque;
    logic [NUM_SPRITES-1:0]                 set_mask;

    always_comb begin
        rom_row_d     = row_a;
        rom_col_d     = col_a;
        hit_pipe_d    = hit_pipe_q;
        ctl_pipe_d    = ctl_pipe_q;
        hit_pipe_d[0] = hit_a;
        ctl_pipe_d[0] = '{frame_start: frame_start, display_on: display_on};
        for (int k = 1; k <= ROM_LATENCY; k++) begin
            hit_pipe_d[k] = hit_pipe_q[k-1];
            ctl_pipe_d[k] = ctl_pipe_q[k-1];
        end
    end

    assign hit_c = hit_pipe_q[ROM_LATENCY];
    assign ctl_c = ctl_pipe_q[ROM_LATENCY];

    // Walk from lowest priority upward so the lowest-index opaque sprite wins.
    always_comb begin
        opaque = '0;
        rgb_d  = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            opaque[i] = hit_c[i] && (rom_data[i] != KEY_COLOUR);
        end
        if (ctl_c.display_on) begin
            rgb_d = BG_COLOUR;
            for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
                if (opaque[i]) begin
                    rgb_d = rom_data[i];
                end
            end
        end
    end

    // A set on the frame_start pixel survives the clear: that pixel is the new frame's.
    always_comb begin
        set_mask = '0;
        if (ctl_c.display_on && opaque[0]) begin
            set_mask    = opaque;
            set_mask[0] = 1'b0;
        end
        mask_d = ctl_c.frame_start ? set_mask : (mask_q | set_mask);
        coll_d = |mask_d;
    end

    always_ff @(posedge VGA_clk) begin
        if (rst) begin
            hit_pipe_q <= '0;
            ctl_pipe_q <= '0;
            rom_row_q  <= '0;
            rom_col_q  <= '0;
            rgb_q      <= '0;
            mask_q     <= '0;
            coll_q     <= 1'b0;
        end else begin
            hit_pipe_q <= hit_pipe_d;
            ctl_pipe_q <= ctl_pipe_d;
            rom_row_q  <= rom_row_d;
            rom_col_q  <= rom_col_d;
            rgb_q      <= rgb_d;
            mask_q     <= mask_d;
            coll_q     <= coll_d;
        end
    end

    assign rom_row        = rom_row_q;
    assign rom_col        = rom_col_q;
    assign RGB            = rgb_q;
    assign collision      = coll_q;
    assign collision_mask = mask_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: a behavioural ROM, a reference pixel
// model feeding a scoreboard queue, and checks as the composited pixels emerge.
module tb_sprite_compositor;
    import sprite_pkg::*;

    localparam int N   = 4;
    localparam int LAT = 3;   // ROM_LATENCY(1) + 2

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 display_on, frame_start;
    logic [15:0]          X, Y;
    logic [N-1:0][15:0]   spr_x, spr_y;
    logic [N-1:0]         spr_en;
    logic [N-1:0]         flip_m;
    logic [N-1:0][7:0]    rom_row, rom_col;
    logic [N-1:0][23:0]   rom_data;
    logic [23:0]          RGB;
    logic                 collision;
    logic [N-1:0]         collision_mask;
    logic [N-1:0]         keyed;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [N-1:0] m_mask = '0;

    typedef struct {
        int          due;
        logic [23:0] rgb;
        logic        coll;
        logic [3:0]  mask;
        string       tag;
    } exp_t;
    exp_t q[$];

    sprite_compositor dut (
        .VGA_clk        (clk),
        .rst            (rst),
        .display_on     (display_on),
        .frame_start    (frame_start),
        .X              (X),
        .Y              (Y),
        .spr_x          (spr_x),
        .spr_y          (spr_y),
        .spr_en         (spr_en),
`ifdef SPRITE_COMPOSITOR_MIRROR_EN
        .spr_flip       (flip_m),
`endif
        .rom_row        (rom_row),
        .rom_col        (rom_col),
        .rom_data       (rom_data),
        .RGB            (RGB),
        .collision      (collision),
        .collision_mask (collision_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sprite ROM contents encode sprite id, row and column; keyed sprites return the key.
    function automatic logic [23:0] rom_f(input int i, input logic [7:0] r, input logic [7:0] c);
        logic [3:0] id;
        id = 4'(i + 1);
        return keyed[i] ? 24'hFF0096 : {id, 4'hA, r, c};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) rom_data[i] <= rom_f(i, rom_row[i], rom_col[i]);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, ".rgb"},  64'(RGB),            64'(e.rgb));
            chk({e.tag, ".coll"}, 64'(collision),      64'(e.coll));
            chk({e.tag, ".mask"}, 64'(collision_mask), 64'(e.mask));
        end
    end

    // Drive one pixel and push what the screen should show LAT cycles later.
    task automatic pix(input logic [15:0] x, input logic [15:0] y, input logic d,
                       input logic f, input string tag);
        exp_t        e;
        logic [15:0] dx, dy;
        logic [7:0]  r, c;
        logic [23:0] col;
        logic [N-1:0] opq, set;
        bit          found;
        X = x; Y = y; display_on = d; frame_start = f;
        opq = '0;
        for (int i = 0; i < N; i++) begin
            dx = x - spr_x[i];
            dy = y - spr_y[i];
            r  = dy[8:1];
            c  = dx[8:1];
            if (flip_m[i]) c = 8'd16 - c;
            col = rom_f(i, r, c);
            if (spr_en[i] && dx < 16'd34 && dy < 16'd24 && col != 24'hFF0096) opq[i] = 1'b1;
        end
        e.rgb = d ? 24'h70C5CE : 24'h0;
        found = 0;
        for (int i = 0; i < N; i++) begin
            if (d && !found && opq[i]) begin
                dx = x - spr_x[i];
                dy = y - spr_y[i];
                c  = flip_m[i] ? 8'd16 - dx[8:1] : dx[8:1];
                e.rgb = rom_f(i, dy[8:1], c);
                found = 1;
            end
        end
        set = (d && opq[0]) ? (opq & 4'b1110) : 4'b0000;
        m_mask = f ? set : (m_mask | set);
        e.due  = cyc + LAT;
        e.coll = |m_mask;
        e.mask = m_mask;
        e.tag  = tag;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic flush();
        repeat (3) pix(16'd0, 16'd0, 1'b0, 1'b0, "flush");
    endtask

    initial begin
        exp_t z;
        int   n;
        rst = 1'b1; display_on = 1'b1; frame_start = 1'b0; X = '0; Y = '0;
        spr_x = '0; spr_y = '0; spr_en = '0; flip_m = '0; keyed = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.rgb",  64'(RGB), 64'h0);
        chk("rst.coll", 64'(collision), 64'h0);
        chk("rst.mask", 64'(collision_mask), 64'h0);
        chk("rst.row",  64'(rom_row), 64'h0);
        chk("rst.col",  64'(rom_col), 64'h0);

        // Pipeline must stay blank until the first post-reset pixel emerges.
        rst = 1'b0;
        spr_x[0] = 16'd100; spr_y[0] = 16'd50; spr_en = 4'b0001;
        z.rgb = '0; z.coll = 0; z.mask = '0; z.tag = "rst_lat";
        z.due = cyc + 1; q.push_back(z);
        z.due = cyc + 2; q.push_back(z);
        pix(16'd99,  16'd50, 1, 0, "x99_bg");
        pix(16'd100, 16'd50, 1, 0, "x100_origin");
        pix(16'd133, 16'd50, 1, 0, "x133_col16");
        pix(16'd134, 16'd50, 1, 0, "x134_bg");
        pix(16'd101, 16'd73, 1, 0, "y73_row11");
        pix(16'd101, 16'd74, 1, 0, "y74_bg");
        pix(16'd120, 16'd60, 0, 0, "disp_off");

        // Priority between sprites 0 and 2 at the same place.
        spr_x[2] = 16'd100; spr_y[2] = 16'd50; spr_en = 4'b0101;
        pix(16'd110, 16'd55, 1, 0, "prio_s0");
        flush(); keyed = 4'b0001;
        pix(16'd110, 16'd55, 1, 0, "prio_s2");
        flush(); keyed = 4'b0101;
        pix(16'd110, 16'd55, 1, 0, "prio_bg");
        flush(); keyed = 4'b0000;

        // Negative sprite position wraps through the modular compare.
        spr_x[1] = 16'hFFF8; spr_y[1] = 16'd10; spr_en = 4'b0010;
        pix(16'd0,  16'd10, 1, 0, "wrap_col4");
        pix(16'd25, 16'd10, 1, 0, "wrap_col16");
        pix(16'd26, 16'd10, 1, 0, "wrap_edge");
        pix(16'd0,  16'd9,  1, 0, "wrap_above");

        // Single-pixel overlap between player and sprite 3.
        spr_x[3] = 16'd133; spr_y[3] = 16'd73; spr_en = 4'b1001;
        pix(16'd0,   16'd0,  0, 1, "fs_clear");
        pix(16'd133, 16'd73, 0, 0, "coll_blank");
        pix(16'd132, 16'd73, 1, 0, "coll_miss");
        pix(16'd133, 16'd73, 1, 0, "coll_hit");
        pix(16'd134, 16'd73, 1, 0, "coll_s3");
        pix(16'd5,   16'd5,  1, 0, "coll_hold");
        pix(16'd5,   16'd5,  1, 1, "coll_fs_clr");
        pix(16'd133, 16'd73, 1, 0, "coll_hit2");
        pix(16'd133, 16'd73, 1, 1, "coll_fs_set");
        pix(16'd6,   16'd5,  1, 0, "coll_kept");

        // Everything disabled: background only, flag cleared and stays clear.
        spr_en = 4'b0000;
        pix(16'd0,   16'd0,  1, 1, "off_fs");
        pix(16'd110, 16'd55, 1, 0, "off_bg");
        pix(16'd133, 16'd73, 1, 0, "off_nocoll");

        // Position change applies to the very next pixel.
        spr_en = 4'b0001;
        pix(16'd100, 16'd50, 1, 0, "move_before");
        spr_x[0] = 16'd50;
        pix(16'd100, 16'd50, 1, 0, "move_after");
        pix(16'd50,  16'd50, 1, 0, "move_new");
`ifdef SPRITE_COMPOSITOR_MIRROR_EN
        spr_x[0] = 16'd100;
        flip_m[0] = 1'b1;
        pix(16'd100, 16'd50, 1, 0, "flip_col16");
        pix(16'd133, 16'd50, 1, 0, "flip_col0");
        pix(16'd100, 16'd50, 0, 0, "flip_blank");
        flip_m[0] = 1'b0;
`endif

        display_on = 1'b0; frame_start = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d results never appeared", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
